// File: rtl/poly_byte_encode.sv
// Serializing ByteEncode12 packer: streams one 256-coefficient polynomial as 128 beats
// of 3 bytes over valid/ready, and accumulates the full 384-byte packed vector.
module poly_byte_encode #(
    parameter int N       = 256,
    parameter int Q       = 3329,
    parameter int COEFF_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N*COEFF_W-1:0] poly_in,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [23:0]          out_bytes,
    output logic [6:0]           out_idx,
    output logic                 busy,
    output logic                 done,
    output logic [N*12-1:0]      packed_bytes
);

    localparam int          BEATS = N / 2;
    localparam int          PW    = N * 12;
    localparam int          SEL_W = $clog2(N * COEFF_W);
    localparam int          PK_W  = $clog2(PW);
    localparam logic [11:0] Q12   = 12'(Q);
    localparam logic [6:0]  LAST  = 7'(BEATS - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [N*COEFF_W-1:0] r_poly;
    logic [6:0]           r_k;
    logic [PW-1:0]        r_packed;
    logic                 r_done;

    logic                 w_start_ok;
    logic                 w_accept;
    logic                 w_last;
    logic [SEL_W-1:0]     w_sel_a;
    logic [SEL_W-1:0]     w_sel_b;
    logic [PK_W-1:0]      w_pk_hi;
    logic [11:0]          w_a;
    logic [11:0]          w_b;
    logic [11:0]          w_da;
    logic [11:0]          w_db;
    logic [23:0]          w_bytes;

    // Single conditional subtract; 12-bit inputs never exceed 2Q, so one step is enough.
    function automatic logic [11:0] reduce_q(input logic [11:0] x);
        return (x >= Q12) ? x - Q12 : x;
    endfunction

    assign w_start_ok = (r_state == IDLE) && start;
    assign w_accept   = (r_state == BUSY) && out_ready;
    assign w_last     = w_accept && (r_k == LAST);

    assign w_sel_a = SEL_W'(r_k) * SEL_W'(2 * COEFF_W);
    assign w_sel_b = w_sel_a + SEL_W'(COEFF_W);
    assign w_pk_hi = PK_W'(PW - 1) - PK_W'(r_k) * PK_W'(24);

    assign w_a     = r_poly[w_sel_a +: 12];
    assign w_b     = r_poly[w_sel_b +: 12];
    assign w_da    = reduce_q(w_a);
    assign w_db    = reduce_q(w_b);
    assign w_bytes = {w_da[7:0], w_db[3:0], w_da[11:8], w_db[11:4]};

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start)  w_next_state = BUSY;
            BUSY:    if (w_last) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: r_poly is a wide data holding register with no reset; it is only observed
    // while BUSY, and out_bytes is gated to zero outside that window.
    always_ff @(posedge clk) begin
        if (w_start_ok) begin
            r_poly <= poly_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_k      <= '0;
            r_packed <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= w_last;
            if (w_start_ok) begin
                r_k      <= '0;
                r_packed <= '0;
            end else if (w_accept) begin
                r_k                  <= r_k + 7'd1;
                r_packed[w_pk_hi -: 24] <= w_bytes;
            end
        end
    end

    assign out_valid    = (r_state == BUSY);
    assign busy         = (r_state == BUSY);
    assign out_idx      = r_k;
    assign out_bytes    = out_valid ? w_bytes : 24'd0;
    assign done         = r_done;
    assign packed_bytes = r_packed;

endmodule

// File: tb/tb_poly_byte_encode.sv
// Directed bench for poly_byte_encode: reset, beat-0 vectors, full frames with and
// without backpressure, mid-frame start and mid-frame reset.
module tb_poly_byte_encode;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [4095:0] poly_in;
    logic          out_ready;
    logic          out_valid;
    logic [23:0]   out_bytes;
    logic [6:0]    out_idx;
    logic          busy;
    logic          done;
    logic [3071:0] packed_bytes;

    int n_vec = 0;
    int n_err = 0;

    poly_byte_encode dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .poly_in      (poly_in),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_bytes    (out_bytes),
        .out_idx      (out_idx),
        .busy         (busy),
        .done         (done),
        .packed_bytes (packed_bytes)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] ref_reduce(input logic [11:0] x);
        return (x >= 12'd3329) ? x - 12'd3329 : x;
    endfunction

    function automatic logic [23:0] ref_beat(input logic [4095:0] p, input int k);
        logic [4095:0] s;
        logic [11:0]   da;
        logic [11:0]   db;
        s  = p >> (32 * k);
        da = ref_reduce(s[11:0]);
        db = ref_reduce(s[27:16]);
        return {da[7:0], db[3:0], da[11:8], db[11:4]};
    endfunction

    function automatic logic [3071:0] ref_packed(input logic [4095:0] p);
        logic [3071:0] acc;
        acc = '0;
        for (int k = 0; k < 128; k++) acc = (acc << 24) | 3072'(ref_beat(p, k));
        return acc;
    endfunction

    function automatic int first_diff(input logic [3071:0] a, input logic [3071:0] b);
        logic [3071:0] x;
        x = a ^ b;
        for (int j = 0; j < 384; j++) begin
            logic [3071:0] s;
            s = x >> (3064 - 8 * j);
            if (s[7:0] != 8'd0) return j;
        end
        return 0;
    endfunction

    function automatic logic [7:0] byte_at(input logic [3071:0] v, input int j);
        logic [3071:0] s;
        s = v >> (3064 - 8 * j);
        return s[7:0];
    endfunction

    function automatic logic [4095:0] rand_poly();
        logic [4095:0] p;
        for (int i = 0; i < 128; i++) p = {p[4063:0], 32'($urandom)};
        return p;
    endfunction

    // Runs one frame from an idle DUT, checking every beat against the model.
    task automatic run_frame(input string name, input logic [4095:0] p, input bit stall,
                             input bit mid_start, output int done_cyc);
        logic [3071:0] exp_pk;
        logic [23:0]   prev_bytes;
        bit            prev_stall;
        bit            done_due;
        bit            finished;
        bit            did_mid;
        int            k;
        int            cyc;
        exp_pk     = ref_packed(p);
        prev_bytes = '0;
        prev_stall = 0;
        done_due   = 0;
        finished   = 0;
        did_mid    = 0;
        k          = 0;
        done_cyc   = -1;
        poly_in    = p;
        out_ready  = 1'b0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!finished && cyc < 2000) begin
            n_vec++;
            if (done !== done_due) begin
                n_err++;
                $display("FAIL %s done cyc=%0d got=%b want=%b", name, cyc, done, done_due);
            end
            if (done_due) begin
                finished = 1;
                done_cyc = cyc;
                n_vec++;
                if (busy !== 1'b0 || out_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s idle_at_done busy=%b valid=%b want 0 0", name, busy, out_valid);
                end
                n_vec++;
                if (packed_bytes !== exp_pk) begin
                    n_err++;
                    $display("FAIL %s packed byte %0d got=%h want=%h", name,
                             first_diff(packed_bytes, exp_pk),
                             byte_at(packed_bytes, first_diff(packed_bytes, exp_pk)),
                             byte_at(exp_pk, first_diff(packed_bytes, exp_pk)));
                end
            end else begin
                n_vec++;
                if (out_valid !== 1'b1 || busy !== 1'b1 || out_idx !== 7'(k)) begin
                    n_err++;
                    $display("FAIL %s beat_ctl cyc=%0d valid=%b busy=%b idx=%0d want 1 1 %0d",
                             name, cyc, out_valid, busy, out_idx, k);
                end
                n_vec++;
                if (out_bytes !== ref_beat(p, k)) begin
                    n_err++;
                    $display("FAIL %s beat %0d got=%h want=%h", name, k, out_bytes, ref_beat(p, k));
                end
                if (prev_stall) begin
                    n_vec++;
                    if (out_bytes !== prev_bytes) begin
                        n_err++;
                        $display("FAIL %s stall_hold beat %0d got=%h want=%h", name, k, out_bytes, prev_bytes);
                    end
                end
                if (mid_start && k == 40 && !did_mid) begin
                    start   = 1'b1;
                    poly_in = ~p;
                    did_mid = 1;
                end else begin
                    start = 1'b0;
                end
                out_ready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                prev_stall = !out_ready;
                prev_bytes = out_bytes;
                if (out_ready) begin
                    if (k == 127) done_due = 1;
                    k++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        start     = 1'b0;
        out_ready = 1'b0;
        if (!finished) begin
            n_vec++;
            n_err++;
            $display("FAIL %s timeout k=%0d got no done want done", name, k);
        end else begin
            n_vec++;
            if (done !== 1'b0 || packed_bytes !== exp_pk) begin
                n_err++;
                $display("FAIL %s after_done done=%b want 0 (packed held=%b)", name, done,
                         packed_bytes === exp_pk);
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        n_vec++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_idx !== 7'd0 ||
            out_bytes !== 24'd0) begin
            n_err++;
            $display("FAIL %s outputs valid=%b busy=%b done=%b idx=%0d bytes=%h want all 0",
                     name, out_valid, busy, done, out_idx, out_bytes);
        end
        n_vec++;
        if (packed_bytes !== '0) begin
            n_err++;
            $display("FAIL %s packed byte %0d got=%h want=00", name,
                     first_diff(packed_bytes, '0), byte_at(packed_bytes, first_diff(packed_bytes, '0)));
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        poly_in   = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");
    endtask

    task automatic test_beat0(input string name, input logic [15:0] c0, input logic [15:0] c1,
                              input logic [23:0] exp);
        logic [3071:0] s;
        int            budget;
        poly_in        = '0;
        poly_in[15:0]  = c0;
        poly_in[31:16] = c1;
        out_ready      = 1'b0;
        start          = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1 || out_idx !== 7'd0 || out_bytes !== exp) begin
            n_err++;
            $display("FAIL %s beat0 valid=%b idx=%0d got=%h want 1 0 %h", name, out_valid,
                     out_idx, out_bytes, exp);
        end
        out_ready = 1'b1;
        budget    = 0;
        while (done !== 1'b1 && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        out_ready = 1'b0;
        s = packed_bytes >> 3048;
        n_vec++;
        if (done !== 1'b1 || s[23:0] !== exp) begin
            n_err++;
            $display("FAIL %s packed0 done=%b got=%h want 1 %h", name, done, s[23:0], exp);
        end
        @(negedge clk);
    endtask

    task automatic test_all_zero();
        int dc;
        run_frame("all_zero", '0, 0, 0, dc);
        n_vec++;
        if (dc !== 129) begin
            n_err++;
            $display("FAIL all_zero done_cycle got=%0d want=129", dc);
        end
    endtask

    task automatic test_random_stall();
        int dc;
        run_frame("rand_stall", rand_poly(), 1, 1, dc);
        n_vec++;
        if (dc < 129) begin
            n_err++;
            $display("FAIL rand_stall done_cycle got=%0d want>=129", dc);
        end
    endtask

    task automatic test_back_to_back();
        int dc;
        run_frame("b2b_a", rand_poly(), 0, 0, dc);
        run_frame("b2b_b", rand_poly(), 0, 0, dc);
        n_vec++;
        if (dc !== 129) begin
            n_err++;
            $display("FAIL b2b done_cycle got=%0d want=129", dc);
        end
    endtask

    task automatic test_reset_mid();
        int budget;
        int dc;
        poly_in   = rand_poly();
        out_ready = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        budget = 0;
        while (out_idx !== 7'd60 && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        n_vec++;
        if (out_idx !== 7'd60) begin
            n_err++;
            $display("FAIL reset_mid reach_beat60 got=%0d want=60", out_idx);
        end
        rst = 1'b1;
        #1;
        check_all_zero("reset_mid");
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_vec++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL reset_mid no_done done=%b busy=%b want 0 0", done, busy);
            end
        end
        run_frame("after_reset", rand_poly(), 0, 0, dc);
        n_vec++;
        if (dc !== 129) begin
            n_err++;
            $display("FAIL after_reset done_cycle got=%0d want=129", dc);
        end
    endtask

    initial begin
        test_reset();
        test_beat0("vec_123_456", 16'h0123, 16'h0456, 24'h236145);
        test_all_zero();
        test_beat0("vec_fff_d00", 16'h0FFF, 16'h0D00, 24'hFE02D0);
        test_beat0("vec_fd01_d01", 16'hFD01, 16'h0D01, 24'h000000);
        test_random_stall();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
